// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution sequencer.
// Holds the sequencer state encoding, kernel geometry and the bit layout of
// the tracking word that travels alongside each window through the MAC pipe.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seqState_e;

    // Square convolution kernel edge; a window completes once KERNEL-1
    // rows and columns of history are available.
    localparam int KERNEL = 3;

    // Tracking word: one bit each for window valid, end-of-line, end-of-frame.
    localparam int TRK_W     = 3;
    localparam int TRK_VALID = 0;
    localparam int TRK_EOL   = 1;
    localparam int TRK_LAST  = 2;

    // Counter width that still works for degenerate sizes of 1.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_valid_pipe.sv
// Enable-gated shift register carrying the window tracking word through the
// MAC pipeline. It advances in lockstep with the MAC datapath registers so
// that the valid/eol/last flags leave at the same time as the result.
module conv_valid_pipe
    import conv_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [TRK_W-1:0] trk_i,
    output logic [TRK_W-1:0] trk_o,
    output logic             anyValid_o
);

    logic [PIPE_LAT-1:0][TRK_W-1:0] stage_q;
    logic [PIPE_LAT-1:0][TRK_W-1:0] stage_d;

    // Next contents of every stage when the pipeline advances by one slot.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = trk_i;
        for (int i = 1; i < PIPE_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; they only move when the MAC pipeline is enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= stage_d;
        end
    end

    // Any window still in flight anywhere in the pipe keeps the frame draining.
    always_comb begin
        anyValid_o = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            anyValid_o = anyValid_o | stage_q[i][TRK_VALID];
        end
    end

    assign trk_o = stage_q[PIPE_LAT-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 convolution datapath.
// Counts incoming pixels, gates the line buffer and MAC pipeline, tracks which
// pipeline slots hold real windows and frames the output AXI-Stream. A single
// start pulse runs one frame; frame_done pulses once every window has left.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic s_axis_tvalid,
    output logic s_axis_tready,
    input  logic s_axis_tlast,
    output logic lb_shift_en,
    output logic pipe_en,
    output logic m_axis_tvalid,
    input  logic m_axis_tready,
    output logic m_axis_tlast,
    output logic m_axis_tuser,
    output logic busy,
    output logic frame_done,
    output logic frame_err
);

    localparam int COL_W = cntWidth(IMG_W);
    localparam int ROW_W = cntWidth(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL - 1);

    seqState_e        state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             frameErr_q, frameErr_d;

    logic             acc;
    logic             colLast;
    logic             lastPix;
    logic             winValid;
    logic [TRK_W-1:0] trkIn;
    logic [TRK_W-1:0] trkOut;
    logic             anyInFlight;

    // A stalled output beat freezes the whole MAC pipeline. The enable only
    // looks at the registered output valid, so there is no path from the
    // input valid back to the input ready.
    assign pipe_en     = ~(m_axis_tvalid & ~m_axis_tready);
    assign acc         = s_axis_tvalid & s_axis_tready;
    assign lb_shift_en = acc;

    assign colLast  = (col_q == COL_LAST);
    assign lastPix  = colLast & (row_q == ROW_LAST);
    assign winValid = acc & (row_q >= ROW_FIRST) & (col_q >= COL_FIRST);
    assign trkIn    = {winValid & lastPix, winValid & colLast, winValid};

    conv_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_validPipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (pipe_en),
        .trk_i      (trkIn),
        .trk_o      (trkOut),
        .anyValid_o (anyInFlight)
    );

    assign m_axis_tvalid = trkOut[TRK_VALID];
    assign m_axis_tuser  = trkOut[TRK_EOL]  & m_axis_tvalid;
    assign m_axis_tlast  = trkOut[TRK_LAST] & m_axis_tvalid;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame progression: run until the final pixel is taken, then wait for
    // the pipeline to empty before reporting completion for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)         state_d = RUN;
            RUN:     if (acc & lastPix) state_d = DRAIN;
            DRAIN:   if (!anyInFlight)  state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Status and input-side handshake decoded from the current state.
    always_comb begin
        s_axis_tready = (state_q == RUN) & pipe_en;
        busy          = (state_q != IDLE);
        frame_done    = (state_q == DONE);
    end

    // Pixel position: column wraps into the next row; the row never wraps
    // because the final pixel moves the sequencer out of RUN.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if ((state_q == IDLE) && start) begin
            col_d = '0;
            row_d = '0;
        end else if (acc) begin
            if (colLast) begin
                col_d = '0;
                if (!lastPix) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Pixel position registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Sticky framing error: the input end marker must coincide exactly with
    // the final pixel. Cleared only when a new frame is launched.
    always_comb begin
        frameErr_d = frameErr_q;
        if ((state_q == IDLE) && start) begin
            frameErr_d = 1'b0;
        end else if (acc && (s_axis_tlast != lastPix)) begin
            frameErr_d = 1'b1;
        end
    end

    // Framing error register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= frameErr_d;
        end
    end

    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer.
// A 4x4 / latency-3 instance carries most scenarios; a 3x3 / latency-1
// instance covers the smallest legal frame. Expected output beats come from
// a list of valid window positions built directly from the frame geometry.
module tb_conv_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int LAT  = 3;
    localparam int NPIX = W * H;

    localparam int W3    = 3;
    localparam int H3    = 3;
    localparam int NPIX3 = W3 * H3;

    logic clk = 1'b0;
    logic rst_n;

    logic start, s_axis_tvalid, s_axis_tready, s_axis_tlast, lb_shift_en, pipe_en;
    logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic busy, frame_done, frame_err;

    logic start3, sValid3, sReady3, sLast3, lbShift3, pipeEn3;
    logic mValid3, mReady3, mLast3, mUser3, busy3, done3, err3;

    int compared   = 0;
    int mismatched = 0;
    bit prevErrExp = 1'b0;

    // Expected output beats of one frame, {tlast, tuser}, in output order.
    bit [1:0] expQ[$];

    always #5 clk = ~clk;

    conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .lb_shift_en(lb_shift_en), .pipe_en(pipe_en),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    conv_frame_sequencer #(.IMG_W(W3), .IMG_H(H3), .PIPE_LAT(1)) dutSmall (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .s_axis_tvalid(sValid3), .s_axis_tready(sReady3),
        .s_axis_tlast(sLast3), .lb_shift_en(lbShift3), .pipe_en(pipeEn3),
        .m_axis_tvalid(mValid3), .m_axis_tready(mReady3),
        .m_axis_tlast(mLast3), .m_axis_tuser(mUser3),
        .busy(busy3), .frame_done(done3), .frame_err(err3)
    );

    task automatic buildExpected(input int w, input int h);
        expQ.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r >= 2 && c >= 2) begin
                    expQ.push_back({(r == h - 1) && (c == w - 1), c == w - 1});
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        start3 = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        sValid3 = 1'b0; sLast3 = 1'b0; mReady3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({busy, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, frame_err,
             s_axis_tready, lb_shift_en} !== 8'b0) begin
            mismatched++;
            $display("[TB] FAIL resetOutputs: got %b expected 00000000",
                     {busy, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done,
                      frame_err, s_axis_tready, lb_shift_en});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            compared++;
            if (busy !== 1'b0 || busy3 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL startInReset: busy=%b busy3=%b expected 0", busy, busy3);
            end
        end
        @(posedge clk); #1;
    endtask

    // validMode: 0 back-to-back, 1 every other cycle, 2 random.
    // readyMode: 0 always ready, 1 five-cycle stall, 2 random.
    task automatic runFrame(input string name, input int validMode, input int readyMode,
                            input int badIdx, input bit checkLat, input int startAgainAt);
        int pixIdx, beats, dones, fc, lastBeatFc, doneFc, acceptFc;
        bit prevStall, errSeen, finished, expErr;
        bit [1:0] prevBits, e;
        int latQ[$];
        pixIdx = 0; beats = 0; dones = 0; fc = 0; lastBeatFc = -10; doneFc = -1;
        prevStall = 1'b0; errSeen = 1'b0; finished = 1'b0; prevBits = 2'b00;
        expErr = (badIdx != NPIX - 1);
        buildExpected(W, H);

        compared++;
        if (frame_err !== prevErrExp) begin
            mismatched++;
            $display("[TB] FAIL %s errSticky: got %b expected %b", name, frame_err, prevErrExp);
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (!finished && fc < 600) begin
            s_axis_tvalid = (pixIdx < NPIX) &&
                            ((validMode == 0) || (validMode == 1 && fc % 2 == 0) ||
                             (validMode == 2 && $urandom_range(0, 1) == 1));
            s_axis_tlast  = s_axis_tvalid && (pixIdx == badIdx);
            if (readyMode == 0)      m_axis_tready = 1'b1;
            else if (readyMode == 1) m_axis_tready = !(fc >= 14 && fc < 19);
            else                     m_axis_tready = ($urandom_range(0, 2) != 0);
            start = (fc == startAgainAt);
            @(negedge clk);

            if (fc == 0) begin
                compared++;
                if (busy !== 1'b1 || frame_err !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL %s started: busy=%b err=%b expected 1/0",
                             name, busy, frame_err);
                end
            end
            if (prevStall) begin
                compared++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tuser} !== prevBits) begin
                    mismatched++;
                    $display("[TB] FAIL %s hold: got v=%b bits=%b expected v=1 bits=%b",
                             name, m_axis_tvalid, {m_axis_tlast, m_axis_tuser}, prevBits);
                end
            end
            compared++;
            if (m_axis_tvalid && !m_axis_tready && s_axis_tready) begin
                mismatched++;
                $display("[TB] FAIL %s freeze: s_axis_tready=1 expected 0 during stall", name);
            end
            compared++;
            if (lb_shift_en !== (s_axis_tvalid & s_axis_tready)) begin
                mismatched++;
                $display("[TB] FAIL %s shiftEn: got %b expected %b",
                         name, lb_shift_en, s_axis_tvalid & s_axis_tready);
            end

            if (s_axis_tvalid && s_axis_tready) begin
                if ((pixIdx / W) >= 2 && (pixIdx % W) >= 2) latQ.push_back(fc);
                pixIdx++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL %s extraBeat: got beat %0d expected none", name, beats);
                end else begin
                    e = expQ.pop_front();
                    if ({m_axis_tlast, m_axis_tuser} !== e) begin
                        mismatched++;
                        $display("[TB] FAIL %s beat%0d: got last/user=%b expected %b",
                                 name, beats, {m_axis_tlast, m_axis_tuser}, e);
                    end
                end
                if (checkLat && latQ.size() > 0) begin
                    acceptFc = latQ.pop_front();
                    compared++;
                    if (fc - acceptFc != LAT) begin
                        mismatched++;
                        $display("[TB] FAIL %s latency: got %0d expected %0d",
                                 name, fc - acceptFc, LAT);
                    end
                end
                beats++;
                lastBeatFc = fc;
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevBits  = {m_axis_tlast, m_axis_tuser};

            if (errSeen) begin
                compared++;
                if (frame_err !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL %s errHold: got %b expected 1", name, frame_err);
                end
            end
            if (frame_err === 1'b1) errSeen = 1'b1;

            if (frame_done === 1'b1) begin
                dones++;
                doneFc = fc;
            end else if (dones > 0) begin
                compared++;
                if (busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL %s busyAfterDone: got %b expected 0", name, busy);
                end
                finished = 1'b1;
            end
            fc++;
            @(posedge clk); #1;
        end
        start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;

        compared++;
        if (!finished) begin
            mismatched++;
            $display("[TB] FAIL %s timeout: got %0d cycles without completion expected done", name, fc);
        end
        compared++;
        if (beats != (W - 2) * (H - 2) || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s beatCount: got %0d expected %0d", name, beats, (W - 2) * (H - 2));
        end
        compared++;
        if (dones != 1 || doneFc != lastBeatFc + 2) begin
            mismatched++;
            $display("[TB] FAIL %s doneTiming: got count %0d at %0d expected 1 at %0d",
                     name, dones, doneFc, lastBeatFc + 2);
        end
        compared++;
        if (frame_err !== expErr || pixIdx != NPIX) begin
            mismatched++;
            $display("[TB] FAIL %s frameErr/pixels: got %b/%0d expected %b/%0d",
                     name, frame_err, pixIdx, expErr, NPIX);
        end
        prevErrExp = expErr;
    endtask

    task automatic test_reset_midframe(input int resetAt);
        int pixIdx, fc;
        pixIdx = 0; fc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_axis_tready = 1'b1;
        while (pixIdx < resetAt && fc < 100) begin
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) pixIdx++;
            fc++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if ({busy, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, frame_err,
             s_axis_tready, lb_shift_en} !== 8'b0 || pixIdx != resetAt) begin
            mismatched++;
            $display("[TB] FAIL midReset%0d: got %b after %0d pixels expected 00000000 after %0d",
                     resetAt, {busy, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done,
                               frame_err, s_axis_tready, lb_shift_en}, pixIdx, resetAt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_axis_tvalid = 1'b0;
        prevErrExp = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_small_frame();
        int pixIdx, fc, beats, acceptFc, beatFc;
        bit [1:0] bits;
        bit finished;
        pixIdx = 0; fc = 0; beats = 0; acceptFc = -1; beatFc = -1; bits = 2'b00;
        finished = 1'b0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        while (!finished && fc < 100) begin
            sValid3 = (pixIdx < NPIX3);
            sLast3  = (pixIdx == NPIX3 - 1);
            @(negedge clk);
            if (sValid3 && sReady3) begin
                if (pixIdx == NPIX3 - 1) acceptFc = fc;
                pixIdx++;
            end
            if (mValid3 && mReady3) begin
                beats++;
                bits = {mLast3, mUser3};
                beatFc = fc;
            end
            if (done3) finished = 1'b1;
            fc++;
            @(posedge clk); #1;
        end
        sValid3 = 1'b0; sLast3 = 1'b0;
        compared++;
        if (!finished || beats != 1 || bits !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL smallFrame: got done=%b beats=%0d bits=%b expected 1/1/11",
                     finished, beats, bits);
        end
        compared++;
        if (beatFc - acceptFc != 1 || err3 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL smallLatency: got %0d err=%b expected 1 err=0",
                     beatFc - acceptFc, err3);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int f = 0; f < 4; f++) begin
            bad = (f % 2 == 1) ? int'($urandom_range(0, NPIX - 1)) : NPIX - 1;
            runFrame($sformatf("random%0d", f), 2, 2, bad, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        runFrame("backToBack", 0, 0, NPIX - 1, 1'b1, -1);
        runFrame("stall", 0, 1, NPIX - 1, 1'b0, -1);
        runFrame("gaps", 1, 0, NPIX - 1, 1'b1, -1);
        runFrame("badTlast", 0, 0, 10, 1'b0, -1);
        runFrame("afterErr", 0, 0, NPIX - 1, 1'b0, -1);
        runFrame("startWhileBusy", 0, 0, NPIX - 1, 1'b1, 5);
        test_reset_midframe(7);
        test_reset_midframe(12);
        runFrame("afterReset", 0, 0, NPIX - 1, 1'b1, -1);
        test_small_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
